// File: rtl/st_bus_frame_counter.sv
// 8-bit loadable ST-BUS frame counter: counts synchronised f0 falling edges.
// Define C4_QUAL_EN to count a frame only after c4 activity since the last one.
module st_bus_frame_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       f0,
  input  logic       c4,
  input  logic [7:0] wdata,
  input  logic       wr,
  output logic [7:0] data_cnt
);

  logic       f0_s1, f0_s2, f0_s3;
  logic [1:0] f0_vld;
  logic       f0_armed;
  logic       frame_ev;
  logic       count_ev;

  // Only arm once a real post-reset high level has reached f0_s2, so a
  // line held low across reset release never yields an edge.
  assign frame_ev = f0_s3 & ~f0_s2 & f0_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      f0_s1    <= 1'b1;
      f0_s2    <= 1'b1;
      f0_s3    <= 1'b1;
      f0_vld   <= 2'b00;
      f0_armed <= 1'b0;
    end else begin
      f0_s1    <= f0;
      f0_s2    <= f0_s1;
      f0_s3    <= f0_s2;
      f0_vld   <= {f0_vld[0], 1'b1};
      f0_armed <= f0_armed | (f0_vld[1] & f0_s2);
    end
  end

`ifdef C4_QUAL_EN
  logic c4_s1, c4_s2, c4_s3;
  logic c4_chg;
  logic c4_seen;

  assign c4_chg   = c4_s2 ^ c4_s3;
  assign count_ev = frame_ev & (c4_seen | c4_chg);

  always_ff @(posedge clk) begin
    if (reset) begin
      c4_s1   <= 1'b1;
      c4_s2   <= 1'b1;
      c4_s3   <= 1'b1;
      c4_seen <= 1'b0;
    end else begin
      c4_s1   <= c4;
      c4_s2   <= c4_s1;
      c4_s3   <= c4_s2;
      c4_seen <= count_ev ? c4_chg : (c4_seen | c4_chg);
    end
  end
`else
  logic unused_c4;

  assign unused_c4 = c4;
  assign count_ev  = frame_ev;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_cnt <= 8'h00;
    end else if (wr) begin
      data_cnt <= wdata;
    end else if (count_ev) begin
      data_cnt <= data_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_st_bus_frame_counter.sv
// Directed bench for st_bus_frame_counter.
// Qualifier checks build only with C4_QUAL_EN.
module tb_st_bus_frame_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       f0;
  logic       c4;
  logic [7:0] wdata;
  logic       wr;
  logic [7:0] data_cnt;

  int vec = 0;
  int err = 0;
  logic [7:0] exp_cnt;

  st_bus_frame_counter dut (
    .clk      (clk),
    .reset    (reset),
    .f0       (f0),
    .c4       (c4),
    .wdata    (wdata),
    .wr       (wr),
    .data_cnt (data_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n, input bit tog);
    for (int i = 1; i <= n; i++) begin
      if (tog && (i % 3 == 0)) c4 = ~c4;
      tick();
    end
  endtask

  task automatic load(input logic [7:0] v);
    wr    = 1'b1;
    wdata = v;
    tick();
    wr    = 1'b0;
    exp_cnt = v;
    chk("load", data_cnt, exp_cnt);
  endtask

  // f0 low for two edges; count moves at the second edge after first low sample
  task automatic pulse(input string tag, input bit inc);
    f0 = 1'b0;
    tick();
    chk({tag, "_k"}, data_cnt, exp_cnt);
    tick();
    chk({tag, "_k1"}, data_cnt, exp_cnt);
    f0 = 1'b1;
    tick();
    if (inc) exp_cnt = exp_cnt + 8'd1;
    chk({tag, "_k2"}, data_cnt, exp_cnt);
  endtask

  initial begin
    reset = 1'b1;
    f0    = 1'b1;
    c4    = 1'b0;
    wr    = 1'b0;
    wdata = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    exp_cnt = 8'h00;
    chk("reset", data_cnt, exp_cnt);
    gap(10, 1'b1);

    load(8'h55);
    wdata = 8'hAA;
    gap(3, 1'b1);
    chk("hold", data_cnt, exp_cnt);

    for (int p = 0; p < 3; p++) begin
      pulse("frame", 1'b1);
      gap(10, 1'b1);
    end
    chk("frame_total", data_cnt, 8'h58);

    load(8'hFE);
    gap(10, 1'b1);
    pulse("wrap_ff", 1'b1);
    gap(10, 1'b1);
    pulse("wrap_00", 1'b1);
    gap(10, 1'b1);
    pulse("wrap_01", 1'b1);
    gap(10, 1'b1);
    chk("wrap_end", data_cnt, 8'h01);

    // wr lands in the cycle frame_ev is high
    f0 = 1'b0;
    tick();
    tick();
    f0    = 1'b1;
    wr    = 1'b1;
    wdata = 8'h10;
    tick();
    wr = 1'b0;
    exp_cnt = 8'h10;
    chk("collide", data_cnt, exp_cnt);
    gap(5, 1'b1);
    chk("collide_drop", data_cnt, exp_cnt);

    wr    = 1'b1;
    wdata = 8'h33;
    tick();
    chk("wr_hold_a", data_cnt, 8'h33);
    wdata = 8'h44;
    tick();
    chk("wr_hold_b", data_cnt, 8'h44);
    wr = 1'b0;
    exp_cnt = 8'h44;
    gap(10, 1'b1);

    // reset with f0 low, f0 kept low across release
    load(8'h77);
    f0    = 1'b0;
    reset = 1'b1;
    tick();
    exp_cnt = 8'h00;
    chk("reset_mid", data_cnt, exp_cnt);
    reset = 1'b0;
    gap(6, 1'b1);
    chk("reset_f0_low", data_cnt, exp_cnt);
    f0 = 1'b1;
    gap(10, 1'b1);
    chk("reset_f0_high", data_cnt, exp_cnt);
    pulse("post_reset", 1'b1);
    gap(10, 1'b1);

`ifdef C4_QUAL_EN
    c4    = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 8'h00;
    gap(10, 1'b0);
    load(8'h20);
    gap(10, 1'b0);
    pulse("qual_static_a", 1'b0);
    gap(10, 1'b0);
    pulse("qual_static_b", 1'b0);
    gap(10, 1'b0);
    chk("qual_static", data_cnt, 8'h20);
    gap(12, 1'b1);
    pulse("qual_toggle", 1'b1);
    gap(5, 1'b0);
    chk("qual_end", data_cnt, 8'h21);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
